actuator_nstream_fsm: RTL and testbench
=======================================

ACTUATOR_NSTREAM_FSM -- requirements
Module: actuator_nstream_fsm

Interface
REQ-001 SHALL have parameter N_STREAMS, default 4, number of streamer channels (sources plus sinks), legal 1..16.
REQ-002 SHALL have parameter ADDR_W, default 32, address width in bits.
REQ-003 SHALL have parameter CNT_W, default 16, iteration-counter width in bits.
REQ-004 SHALL have parameter TIMEOUT, default 0, maximum DISPATCH wait in cycles; 0 disables the watchdog.
REQ-005 SHALL have ports:
  clk_i  in  1  clock; one clock, rising edge.
  rst_ni  in  1  reset, asynchronous, active-low.
  clear_i  in  1  synchronous soft clear.
  start_i  in  1  job start pulse from slave.
  abort_i  in  1  job abort pulse.
  n_iter_i  in  CNT_W  iterations per job.
  base_addr_i  in  N_STREAMS*ADDR_W  per-stream base address.
  stride_i  in  N_STREAMS*ADDR_W  per-stream byte advance per iteration.
  ready_start_i  in  N_STREAMS  per-stream streamer ready flag.
  eng_done_i  in  1  engine iteration-done pulse.
  req_start_o  out  N_STREAMS  per-stream start pulse.
  addr_o  out  N_STREAMS*ADDR_W  per-stream current address.
  eng_start_o  out  1  engine start pulse.
  eng_clear_o  out  1  engine clear.
  eng_enable_o  out  1  engine enable.
  done_o  out  1  job-complete pulse.
  err_o  out  1  watchdog-timeout flag.
  aborted_o  out  1  job-aborted flag.
  busy_o  out  1  job in progress.
  iter_cnt_o  out  CNT_W  iterations completed.

Function
REQ-006 SHALL implement states IDLE, DISPATCH, COMPUTE, DRAIN.
REQ-007 IDLE, start_i=1 and n_iter_i!=0: latch n_iter_i, zero offsets, iter_cnt, err_o and aborted_o, then go to DISPATCH.
REQ-008 IDLE, start_i=1 and n_iter_i=0: go to DRAIN, issuing no req_start_o.
REQ-009 DISPATCH, all ready_start_i=1: in the same cycle, req_start_o all ones and eng_start_o=1; go to COMPUTE.
REQ-010 DISPATCH, any ready_start_i=0: stay in DISPATCH; eng_enable_o=0; wait counter increments.
REQ-011 COMPUTE, eng_done_i=1: iter_cnt+1; each offset[i]+=stride[i].
REQ-011a COMPUTE, eng_done_i=1: if the new iter_cnt equals the latched n_iter, go to DRAIN; otherwise go to DISPATCH.
REQ-012 DRAIN: eng_enable_o=0; wait until all ready_start_i=1, then pulse done_o for 1 cycle and go to IDLE.
REQ-013 addr_o[i] SHALL equal base_addr_i[i]+offset[i], combinational, modulo 2^ADDR_W (wrap, no flag).
REQ-014 eng_clear_o SHALL be 1 only in IDLE.
REQ-015 eng_enable_o SHALL be 1 in IDLE, COMPUTE, and in DISPATCH on the dispatch cycle; 0 otherwise.
REQ-016 busy_o SHALL equal (state!=IDLE).
REQ-017 The wait counter SHALL reset on every entry to DISPATCH.
REQ-018 Watchdog: TIMEOUT!=0 and wait counter reaches TIMEOUT in DISPATCH: set err_o (sticky until next accepted start); go to DRAIN.
REQ-019 abort_i in DISPATCH or COMPUTE: set aborted_o (sticky until next accepted start); go to DRAIN; eng_done_i in that same cycle is ignored.
REQ-020 abort_i in IDLE or DRAIN SHALL be ignored.
REQ-021 start_i outside IDLE SHALL be ignored.
REQ-022 Abort has priority over watchdog; watchdog has priority over dispatch.
REQ-023 eng_done_i outside COMPUTE SHALL be ignored.
REQ-024 iter_cnt_o SHALL saturate at 2^CNT_W-1.

Reset
REQ-025 rst_ni=0 SHALL asynchronously force state IDLE; offsets, iter_cnt, wait counter, err_o and aborted_o to 0.
REQ-026 After reset, all pulse outputs SHALL be 0, eng_clear_o=1, eng_enable_o=1, busy_o=0.
REQ-027 clear_i=1 SHALL have the same effect as reset at the next clock edge, with priority over all other inputs, including mid-job.

Verification
REQ-028 N_STREAMS=4, n_iter=3, base[i]=0x1000*i, stride=4, ready all 1, eng_done 2 cycles after each start.
  -> 3 dispatches with addr_o[1]=0x1000, 0x1004, 0x1008; done_o 1 pulse; iter_cnt_o=3.
REQ-029 ready_start_i[2]=0 for 5 cycles at the 2nd dispatch, TIMEOUT=0.
  -> req_start_o held off 5 cycles, then dispatches; eng_enable_o=0 during the wait; done_o eventually.
REQ-030 TIMEOUT=8, ready_start_i[0] stuck at 0 in DISPATCH.
  -> DRAIN entered after 8 cycles; err_o=1; done_o after ready recovers; err_o cleared by next start.
REQ-031 abort_i coincident with eng_done_i at iteration 1 of 4.
  -> iter_cnt_o stays 0; aborted_o=1; DRAIN then done_o; no further req_start_o.
REQ-032 Start with n_iter_i=0; also stride=0x10, base=0xFFFFFFF8, ADDR_W=32.
  -> n_iter_i=0: no req_start_o, done_o pulse.
  -> stride/base case: addr_o wraps to 0x00000008 on the 2nd iteration.
REQ-033 rst_ni low in COMPUTE, and separately clear_i high in COMPUTE.
  -> Both: state IDLE, busy_o=0, iter_cnt_o=0, no done_o.

Source files
------------

// File: rtl/actuator_nstream_fsm.sv
// Job sequencer for an N-stream accelerator: dispatches streamers and the engine once per
// iteration, advances per-stream addresses, and handles abort, watchdog and drain.
// state    | meaning
// IDLE     | engine held in clear, waiting for a job start
// DISPATCH | waiting for every streamer to be ready, then starts them with the engine
// COMPUTE  | engine running one iteration
// DRAIN    | waiting for streamers to go idle before reporting done
module actuator_nstream_fsm #(
    parameter int N_STREAMS = 4,
    parameter int ADDR_W    = 32,
    parameter int CNT_W     = 16,
    parameter int TIMEOUT   = 0
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clear_i,
    input  logic                          start_i,
    input  logic                          abort_i,
    input  logic [CNT_W-1:0]              n_iter_i,
    input  logic [N_STREAMS*ADDR_W-1:0]   base_addr_i,
    input  logic [N_STREAMS*ADDR_W-1:0]   stride_i,
    input  logic [N_STREAMS-1:0]          ready_start_i,
    input  logic                          eng_done_i,
    output logic [N_STREAMS-1:0]          req_start_o,
    output logic [N_STREAMS*ADDR_W-1:0]   addr_o,
    output logic                          eng_start_o,
    output logic                          eng_clear_o,
    output logic                          eng_enable_o,
    output logic                          done_o,
    output logic                          err_o,
    output logic                          aborted_o,
    output logic                          busy_o,
    output logic [CNT_W-1:0]              iter_cnt_o
);

    typedef enum logic [1:0] {IDLE, DISPATCH, COMPUTE, DRAIN} state_e;

    localparam int                WAIT_W    = 32;
    localparam logic [WAIT_W-1:0] TIMEOUT_L = WAIT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  ITER_MAX  = '1;

    state_e              state;
    logic [CNT_W-1:0]    n_iter_q;
    logic [CNT_W-1:0]    iter_cnt_q;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [ADDR_W-1:0]   offset [N_STREAMS];
    logic                err_q;
    logic                aborted_q;

    logic                all_ready;
    logic                timeout_hit;
    logic                dispatch_fire;
    logic                done_fire;
    logic [CNT_W-1:0]    iter_next;

    assign all_ready     = &ready_start_i;
    // The watchdog fires on the cycle the wait count would reach TIMEOUT, so DISPATCH
    // never lasts more than TIMEOUT cycles; it outranks a late-arriving ready.
    assign timeout_hit   = (TIMEOUT != 0) && (state == DISPATCH)
                           && ((wait_cnt + WAIT_W'(1)) == TIMEOUT_L);
    assign dispatch_fire = !clear_i && (state == DISPATCH) && all_ready
                           && !abort_i && !timeout_hit;
    assign done_fire     = !clear_i && (state == DRAIN) && all_ready;
    assign iter_next     = (iter_cnt_q == ITER_MAX) ? iter_cnt_q : iter_cnt_q + CNT_W'(1);

    assign req_start_o  = {N_STREAMS{dispatch_fire}};
    assign eng_start_o  = dispatch_fire;
    assign eng_clear_o  = (state == IDLE);
    assign eng_enable_o = (state == IDLE) || (state == COMPUTE) || dispatch_fire;
    assign done_o       = done_fire;
    assign err_o        = err_q;
    assign aborted_o    = aborted_q;
    assign busy_o       = (state != IDLE);
    assign iter_cnt_o   = iter_cnt_q;

    for (genvar g = 0; g < N_STREAMS; g++) begin : g_addr
        assign addr_o[g*ADDR_W +: ADDR_W] = base_addr_i[g*ADDR_W +: ADDR_W] + offset[g];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            n_iter_q   <= '0;
            iter_cnt_q <= '0;
            wait_cnt   <= '0;
            err_q      <= 1'b0;
            aborted_q  <= 1'b0;
            for (int i = 0; i < N_STREAMS; i++) offset[i] <= '0;
        end else if (clear_i) begin
            state      <= IDLE;
            n_iter_q   <= '0;
            iter_cnt_q <= '0;
            wait_cnt   <= '0;
            err_q      <= 1'b0;
            aborted_q  <= 1'b0;
            for (int i = 0; i < N_STREAMS; i++) offset[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        n_iter_q   <= n_iter_i;
                        iter_cnt_q <= '0;
                        wait_cnt   <= '0;
                        err_q      <= 1'b0;
                        aborted_q  <= 1'b0;
                        for (int i = 0; i < N_STREAMS; i++) offset[i] <= '0;
                        state      <= (n_iter_i == '0) ? DRAIN : DISPATCH;
                    end
                end
                DISPATCH: begin
                    if (abort_i) begin
                        aborted_q <= 1'b1;
                        state     <= DRAIN;
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                        state <= DRAIN;
                    end else if (all_ready) begin
                        state <= COMPUTE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                COMPUTE: begin
                    if (abort_i) begin
                        aborted_q <= 1'b1;
                        state     <= DRAIN;
                    end else if (eng_done_i) begin
                        iter_cnt_q <= iter_next;
                        wait_cnt   <= '0;
                        for (int i = 0; i < N_STREAMS; i++)
                            offset[i] <= offset[i] + stride_i[i*ADDR_W +: ADDR_W];
                        state <= (iter_next == n_iter_q) ? DRAIN : DISPATCH;
                    end
                end
                DRAIN: begin
                    if (all_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_actuator_nstream_fsm.sv
// Directed and randomized job sequences; each job's expected addresses, counts and flags
// come from plain arithmetic over the job parameters (base + k*stride, iterations done).
module tb_actuator_nstream_fsm;

    localparam int NS = 4;
    localparam int AW = 32;
    localparam int CW = 16;
    localparam int TO = 8;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b1;
    logic              clear_i = 1'b0;
    logic              start_i = 1'b0;
    logic              abort_i = 1'b0;
    logic [CW-1:0]     n_iter_i = '0;
    logic [NS*AW-1:0]  base_addr_i = '0;
    logic [NS*AW-1:0]  stride_i = '0;
    logic [NS-1:0]     ready_start_i = '1;
    logic              eng_done_i = 1'b0;
    logic [NS-1:0]     req_start_o;
    logic [NS*AW-1:0]  addr_o;
    logic              eng_start_o, eng_clear_o, eng_enable_o, done_o;
    logic              err_o, aborted_o, busy_o;
    logic [CW-1:0]     iter_cnt_o;

    actuator_nstream_fsm #(
        .N_STREAMS(NS), .ADDR_W(AW), .CNT_W(CW), .TIMEOUT(TO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
        .abort_i(abort_i), .n_iter_i(n_iter_i), .base_addr_i(base_addr_i),
        .stride_i(stride_i), .ready_start_i(ready_start_i), .eng_done_i(eng_done_i),
        .req_start_o(req_start_o), .addr_o(addr_o), .eng_start_o(eng_start_o),
        .eng_clear_o(eng_clear_o), .eng_enable_o(eng_enable_o), .done_o(done_o),
        .err_o(err_o), .aborted_o(aborted_o), .busy_o(busy_o), .iter_cnt_o(iter_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_fail = 0;
    logic [AW-1:0] base_m   [NS];
    logic [AW-1:0] stride_m [NS];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load_streams(input int mode);
        for (int i = 0; i < NS; i++) begin
            case (mode)
                0: begin base_m[i] = AW'(32'h1000 * i); stride_m[i] = 32'd4; end
                1: begin base_m[i] = 32'hFFFF_FFF8;     stride_m[i] = 32'h10; end
                default: begin base_m[i] = $urandom;    stride_m[i] = $urandom; end
            endcase
            base_addr_i[i*AW +: AW] = base_m[i];
            stride_i[i*AW +: AW]    = stride_m[i];
        end
    endtask

    task automatic check_addr(input string tag, input int iter);
        for (int i = 0; i < NS; i++) begin
            logic [AW-1:0] e;
            e = base_m[i] + stride_m[i] * AW'(iter);
            chk($sformatf("%s_addr%0d_it%0d", tag, i, iter), addr_o[i*AW +: AW], e);
        end
    endtask

    // kill_mode: 1 = async reset, 2 = soft clear, applied in COMPUTE of iteration kill_k
    task automatic run_job(input int n, input bit rnd, input int hold_k, input int hold_s,
                           input int hold_len, input int abort_k, input int kill_k,
                           input int kill_mode);
        int iter = 0;
        bit timed_out = 0;
        bit aborted = 0;
        bit stop = 0;
        int d;
        n_iter_i = CW'(n);
        start_i = 1'b1;
        abort_i = rnd ? 1'($urandom) : 1'b0;
        eng_done_i = 1'b1;
        ready_start_i = NS'($urandom);
        #1;
        chk("idle_busy", busy_o, 0);
        chk("idle_clear", eng_clear_o, 1);
        chk("idle_enable", eng_enable_o, 1);
        chk("idle_req", req_start_o, 0);
        chk("idle_done", done_o, 0);
        @(negedge clk_i);
        start_i = 1'b0; abort_i = 1'b0; eng_done_i = 1'b0;
        for (int k = 0; k < n && !stop; k++) begin
            int h, s, lat;
            h   = (k == hold_k) ? hold_len : (rnd ? int'($urandom_range(0, 2)) : 0);
            s   = (k == hold_k) ? hold_s : int'($urandom_range(0, NS - 1));
            lat = rnd ? int'($urandom_range(0, 3)) : 1;
            for (int c = 0; c <= h && !stop; c++) begin
                ready_start_i = (c < h) ? ~(NS'(1) << s) : '1;
                eng_done_i = rnd ? 1'($urandom) : 1'b0;
                #1;
                chk("dsp_busy", busy_o, 1);
                chk("dsp_clear", eng_clear_o, 0);
                chk("dsp_iter", iter_cnt_o, k);
                chk("dsp_err", err_o, 0);
                chk("dsp_aborted", aborted_o, 0);
                chk("dsp_done", done_o, 0);
                if (c == TO - 1) begin
                    chk("wd_req", req_start_o, 0);
                    chk("wd_enable", eng_enable_o, 0);
                    timed_out = 1; stop = 1;
                end else if (c < h) begin
                    chk("hold_req", req_start_o, 0);
                    chk("hold_estart", eng_start_o, 0);
                    chk("hold_enable", eng_enable_o, 0);
                end else begin
                    chk("dsp_req", req_start_o, {NS{1'b1}});
                    chk("dsp_estart", eng_start_o, 1);
                    chk("dsp_enable", eng_enable_o, 1);
                    check_addr("dsp", k);
                end
                @(negedge clk_i);
            end
            if (!stop) begin
                eng_done_i = 1'b0;
                for (int c = 0; c < lat; c++) begin
                    ready_start_i = NS'($urandom);
                    #1;
                    chk("cmp_busy", busy_o, 1);
                    chk("cmp_enable", eng_enable_o, 1);
                    chk("cmp_req", req_start_o, 0);
                    chk("cmp_iter", iter_cnt_o, k);
                    @(negedge clk_i);
                end
                eng_done_i = 1'b1;
                abort_i = (k == abort_k);
                if (k == kill_k && kill_mode == 1) begin
                    #2 rst_ni = 1'b0;
                    #1;
                    chk("rst_busy", busy_o, 0);
                    chk("rst_iter", iter_cnt_o, 0);
                    chk("rst_clear", eng_clear_o, 1);
                    chk("rst_enable", eng_enable_o, 1);
                    chk("rst_done", done_o, 0);
                    @(negedge clk_i);
                    rst_ni = 1'b1; eng_done_i = 1'b0; abort_i = 1'b0;
                    #1;
                    chk("rst_done2", done_o, 0);
                    check_addr("rst", 0);
                    @(negedge clk_i);
                    return;
                end
                if (k == kill_k && kill_mode == 2) begin
                    clear_i = 1'b1;
                    #1;
                    chk("clr_done", done_o, 0);
                    @(negedge clk_i);
                    clear_i = 1'b0; eng_done_i = 1'b0; abort_i = 1'b0;
                    #1;
                    chk("clr_busy", busy_o, 0);
                    chk("clr_iter", iter_cnt_o, 0);
                    chk("clr_clear", eng_clear_o, 1);
                    chk("clr_done2", done_o, 0);
                    check_addr("clr", 0);
                    @(negedge clk_i);
                    return;
                end
                #1;
                chk("cmp_done", done_o, 0);
                @(negedge clk_i);
                if (abort_i) begin aborted = 1; stop = 1; end
                else iter++;
                eng_done_i = 1'b0; abort_i = 1'b0;
            end
        end
        d = rnd ? int'($urandom_range(0, 3)) : 2;
        for (int c = 0; c <= d; c++) begin
            ready_start_i = (c < d) ? ~(NS'(1) << $urandom_range(0, NS - 1)) : '1;
            abort_i = 1'($urandom); start_i = 1'($urandom); eng_done_i = 1'($urandom);
            #1;
            chk("drn_busy", busy_o, 1);
            chk("drn_enable", eng_enable_o, 0);
            chk("drn_clear", eng_clear_o, 0);
            chk("drn_req", req_start_o, 0);
            chk("drn_estart", eng_start_o, 0);
            chk("drn_iter", iter_cnt_o, iter);
            chk("drn_err", err_o, timed_out);
            chk("drn_aborted", aborted_o, aborted);
            chk("drn_done", done_o, (c == d));
            check_addr("drn", iter);
            @(negedge clk_i);
        end
        start_i = 1'b0; abort_i = 1'b0; eng_done_i = 1'b0;
        #1;
        chk("end_busy", busy_o, 0);
        chk("end_done", done_o, 0);
        chk("end_clear", eng_clear_o, 1);
        chk("end_iter", iter_cnt_o, iter);
        chk("end_err", err_o, timed_out);
        chk("end_aborted", aborted_o, aborted);
        @(negedge clk_i);
    endtask

    initial begin
        #2 rst_ni = 1'b0;
        #1;
        chk("reset_busy", busy_o, 0);
        chk("reset_clear", eng_clear_o, 1);
        chk("reset_enable", eng_enable_o, 1);
        chk("reset_done", done_o, 0);
        chk("reset_req", req_start_o, 0);
        chk("reset_estart", eng_start_o, 0);
        chk("reset_err", err_o, 0);
        chk("reset_aborted", aborted_o, 0);
        chk("reset_iter", iter_cnt_o, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        load_streams(0);
        run_job(3, 0, -1, 0, 0, -1, -1, 0);   // three plain iterations
        run_job(4, 0, 1, 2, 5, -1, -1, 0);    // stream 2 late by 5 cycles at 2nd dispatch
        run_job(3, 0, 0, 0, 20, -1, -1, 0);   // stream 0 stuck: watchdog
        run_job(2, 0, -1, 0, 0, -1, -1, 0);   // error flag cleared by new start
        run_job(4, 0, -1, 0, 0, 0, -1, 0);    // abort together with first eng_done
        run_job(0, 0, -1, 0, 0, -1, -1, 0);   // zero-iteration job
        load_streams(1);
        run_job(3, 0, -1, 0, 0, -1, -1, 0);   // address wraps on 2nd iteration
        run_job(4, 0, -1, 0, 0, -1, 1, 1);    // async reset mid-job
        run_job(4, 0, -1, 0, 0, -1, 0, 2);    // soft clear mid-job
        for (int j = 0; j < 10; j++) begin
            load_streams(2);
            run_job(int'($urandom_range(0, 5)), 1, int'($urandom_range(0, 4)),
                    int'($urandom_range(0, NS - 1)), int'($urandom_range(0, 10)),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1, -1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
